hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter XLEN_RD, default 5, width of register-index fields.
REQ-002 SHALL have parameter CNT_W, default 16, width of performance counters.
REQ-003 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have ports rs1_id, rs2_id, rd_id, input, XLEN_RD, source and destination indices of the instruction in ID.
REQ-006 SHALL have ports RegWrite_id, MemRead_id, input, 1 each, ID-stage control bits.
REQ-007 SHALL have port redirect_exe, input, 1, taken branch or jump resolved in EXE.
REQ-008 SHALL have ports forward_rd1_exe, forward_rd2_exe, output, 2 each: 00 register file, 01 MEM ALU result, 10 WB result; 11 never driven.
REQ-009 SHALL have ports stall_if, stall_id, output, 1 each, hold PC and IF/ID register.
REQ-010 SHALL have ports flush_id, flush_exe, output, 1 each, clear IF/ID or ID/EX register to a bubble.
REQ-011 SHALL have ports stall_count, flush_count, output, CNT_W each, event counters.

Function
REQ-012 SHALL keep internal scoreboard registers for EX, MEM and WB slots, each holding rd, RegWrite and MemRead; EX additionally holds rs1 and rs2.
REQ-013 SHALL compute load_use = MemRead_ex & RegWrite_ex & (rd_ex != 0) & ((rd_ex == rs1_id) | (rd_ex == rs2_id)), combinationally.
REQ-014 SHALL drive stall_if = stall_id = load_use & ~redirect_exe, combinationally, same cycle.
REQ-015 SHALL drive flush_exe = load_use | redirect_exe and flush_id = redirect_exe, combinationally.
REQ-016 SHALL give redirect_exe priority over load_use: on both, no stall, both flushes asserted.
REQ-017 SHALL, each clock edge, shift MEM into WB and EX into MEM unconditionally.
REQ-018 SHALL load the EX slot from ID fields when flush_exe is 0, else load a bubble (rd=0, RegWrite=0, MemRead=0, rs1=rs2=0).
REQ-019 SHALL compute forward_rd1_exe from rs1_ex: 01 if RegWrite_mem & rd_mem!=0 & rd_mem==rs1_ex; else 10 if RegWrite_wb & rd_wb!=0 & rd_wb==rs1_ex; else 00.
REQ-020 SHALL compute forward_rd2_exe identically from rs2_ex.
REQ-021 SHALL give MEM priority over WB when both match the same source (youngest producer wins).
REQ-022 SHALL never forward for index 0, regardless of RegWrite.
REQ-023 SHALL not forward a load from MEM slot; REQ-014 stall guarantees the load reaches WB first.
REQ-024 SHALL increment stall_count by 1 on each cycle with stall_id=1 and flush_count by 1 on each cycle with flush_id=1, both wrapping modulo 2^CNT_W.
REQ-025 SHALL leave WB-to-ID same-cycle hazards to register-file write-before-read; no output for them.
REQ-026 SHALL insert exactly one bubble per load-use hazard; a stall lasts exactly one cycle since the load then leaves EX.

Reset
REQ-027 SHALL, on reset assertion, asynchronously clear all scoreboard slots to bubbles and both counters to 0.
REQ-028 SHALL, during reset, drive forward selects 00, stall_if/stall_id/flush_id/flush_exe 0.
REQ-029 SHALL, on reset mid-stall, drop the stall immediately and resume from empty pipeline after release.

Verification
REQ-030 SHALL pass: add x5 in EX then add using rs1=x5 next -> forward_rd1_exe=01 one cycle, then 00 for an instruction 3 behind.
REQ-031 SHALL pass: lw x6 then add rs2=x6 -> stall_if=stall_id=flush_exe=1 one cycle, stall_count=1, then forward_rd2_exe=10.
REQ-032 SHALL pass: writes to x7 in both MEM and WB, EX reads x7 -> select 01; writes to x0 in MEM -> select 00.
REQ-033 SHALL pass: load-use and redirect_exe same cycle -> stall_id=0, flush_id=flush_exe=1, flush_count=1.
REQ-034 SHALL pass: stall_count preset to 0xFFFF via 65535 stalls, one more stall -> 0x0000.
REQ-035 SHALL pass: reset asserted mid-stall, no clock edge -> all outputs 0 immediately, counters 0.

Source files
------------

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Purpose:
//   Data- and control-hazard unit for a classic five-stage in-order pipeline
//   (IF, ID, EXE, MEM, WB). It keeps a small scoreboard with the destination,
//   RegWrite and MemRead bits of the instructions in EXE, MEM and WB. The EXE
//   entry also holds the source indices of that instruction.
//
//   From that scoreboard the unit produces three things:
//     - forwarding selects for the two EXE operands.
//     - a one-cycle stall plus bubble for load-use hazards.
//     - flushes for redirects resolved in EXE.
//   It also counts stall cycles and flush cycles for performance monitoring.
//
// Ports:
//   clk                    sole clock; all state updates on the rising edge
//   reset                  asynchronous, active-high; empties the scoreboard
//                          and clears both counters
//   rs1_id/rs2_id/rd_id    source and destination indices of the ID instruction
//   RegWrite_id/MemRead_id ID-stage control bits
//   redirect_exe           taken branch/jump resolved in EXE
//   forward_rd1_exe/2_exe  operand select: 00 regfile, 01 MEM ALU result,
//                          10 WB result (11 is never produced)
//   stall_if/stall_id      hold PC and the IF/ID register
//   flush_id/flush_exe     turn IF/ID or ID/EX into a bubble
//   stall_count            cycles with stall_id=1, wraps modulo 2^CNT_W
//   flush_count            cycles with flush_id=1, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int XLEN_RD = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN_RD-1:0] rs1_id,
  input  logic [XLEN_RD-1:0] rs2_id,
  input  logic [XLEN_RD-1:0] rd_id,
  input  logic               RegWrite_id,
  input  logic               MemRead_id,
  input  logic               redirect_exe,
  output logic [1:0]         forward_rd1_exe,
  output logic [1:0]         forward_rd2_exe,
  output logic               stall_if,
  output logic               stall_id,
  output logic               flush_id,
  output logic               flush_exe,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  localparam logic [XLEN_RD-1:0] REG_X0 = '0;

  // Scoreboard slots
  logic [XLEN_RD-1:0] rd_ex_q, rd_ex_d, rs1_ex_q, rs1_ex_d, rs2_ex_q, rs2_ex_d;
  logic               RegWrite_ex_q, RegWrite_ex_d, MemRead_ex_q, MemRead_ex_d;
  logic [XLEN_RD-1:0] rd_mem_q, rd_mem_d;
  logic               RegWrite_mem_q, RegWrite_mem_d, MemRead_mem_q, MemRead_mem_d;
  logic [XLEN_RD-1:0] rd_wb_q, rd_wb_d;
  logic               RegWrite_wb_q, RegWrite_wb_d, MemRead_wb_q, MemRead_wb_d;

  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;

  logic               load_use;
  logic               stall_raw;
  logic               flush_exe_raw;

  // A load in EXE whose result the ID instruction needs cannot be forwarded
  // in time, so ID must wait one cycle.
  always_comb begin
    load_use = MemRead_ex_q & RegWrite_ex_q & (rd_ex_q != REG_X0) &
               ((rd_ex_q == rs1_id) | (rd_ex_q == rs2_id));
  end

  // A redirect kills the ID instruction anyway, so it overrides the stall.
  assign stall_raw     = load_use & ~redirect_exe;
  assign flush_exe_raw = load_use | redirect_exe;

  // The scoreboard is already empty while reset is held, so load_use is 0.
  // redirect_exe comes from outside and still has to be masked here.
  assign stall_if  = stall_raw & ~reset;
  assign stall_id  = stall_raw & ~reset;
  assign flush_id  = redirect_exe & ~reset;
  assign flush_exe = flush_exe_raw & ~reset;

  // Operand forwarding. The MEM stage is checked first because it holds the
  // youngest producer. A load sitting in MEM never meets a dependent
  // instruction in EXE: the load-use stall places a bubble between them, and
  // the consumer then takes the value from WB.
  logic [XLEN_RD-1:0] src_ex [2];
  logic [1:0]         fwd_sel [2];

  assign src_ex[0] = rs1_ex_q;
  assign src_ex[1] = rs2_ex_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (RegWrite_mem_q && (rd_mem_q != REG_X0) && (rd_mem_q == src_ex[gi])) begin
          fwd_sel[gi] = 2'b01;
        end else if (RegWrite_wb_q && (rd_wb_q != REG_X0) && (rd_wb_q == src_ex[gi])) begin
          fwd_sel[gi] = 2'b10;
        end
      end
    end
  endgenerate

  assign forward_rd1_exe = fwd_sel[0];
  assign forward_rd2_exe = fwd_sel[1];

  // Next-state logic. MEM and WB always advance. EXE takes either the ID
  // instruction or a bubble.
  always_comb begin
    rd_wb_d        = rd_mem_q;
    RegWrite_wb_d  = RegWrite_mem_q;
    MemRead_wb_d   = MemRead_mem_q;

    rd_mem_d       = rd_ex_q;
    RegWrite_mem_d = RegWrite_ex_q;
    MemRead_mem_d  = MemRead_ex_q;

    if (flush_exe_raw) begin
      rd_ex_d       = REG_X0;
      rs1_ex_d      = REG_X0;
      rs2_ex_d      = REG_X0;
      RegWrite_ex_d = 1'b0;
      MemRead_ex_d  = 1'b0;
    end else begin
      rd_ex_d       = rd_id;
      rs1_ex_d      = rs1_id;
      rs2_ex_d      = rs2_id;
      RegWrite_ex_d = RegWrite_id;
      MemRead_ex_d  = MemRead_id;
    end

    stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, stall_raw};
    flush_count_d = flush_count_q + {{(CNT_W-1){1'b0}}, redirect_exe};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ex_q        <= REG_X0;
      rs1_ex_q       <= REG_X0;
      rs2_ex_q       <= REG_X0;
      RegWrite_ex_q  <= 1'b0;
      MemRead_ex_q   <= 1'b0;
      rd_mem_q       <= REG_X0;
      RegWrite_mem_q <= 1'b0;
      MemRead_mem_q  <= 1'b0;
      rd_wb_q        <= REG_X0;
      RegWrite_wb_q  <= 1'b0;
      MemRead_wb_q   <= 1'b0;
      stall_count_q  <= '0;
      flush_count_q  <= '0;
    end else begin
      rd_ex_q        <= rd_ex_d;
      rs1_ex_q       <= rs1_ex_d;
      rs2_ex_q       <= rs2_ex_d;
      RegWrite_ex_q  <= RegWrite_ex_d;
      MemRead_ex_q   <= MemRead_ex_d;
      rd_mem_q       <= rd_mem_d;
      RegWrite_mem_q <= RegWrite_mem_d;
      MemRead_mem_q  <= MemRead_mem_d;
      rd_wb_q        <= rd_wb_d;
      RegWrite_wb_q  <= RegWrite_wb_d;
      MemRead_wb_q   <= MemRead_wb_d;
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Purpose:
//   Self-checking bench for hazard_unit. A driver applies one ID instruction
//   per cycle. For each cycle it predicts the outputs from a list-of-
//   instructions model of the pipeline and queues that prediction. A monitor
//   samples the DUT on every falling edge and checks it against the head of
//   the queue.
//
//   The counters use a narrow width so that the wrap can be reached in a
//   short run.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int XLEN_RD = 5;
  localparam int CNT_W   = 8;
  localparam int CMOD    = 1 << CNT_W;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [XLEN_RD-1:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
  logic               RegWrite_id = 1'b0, MemRead_id = 1'b0, redirect_exe = 1'b1;
  logic [1:0]         forward_rd1_exe, forward_rd2_exe;
  logic               stall_if, stall_id, flush_id, flush_exe;
  logic [CNT_W-1:0]   stall_count, flush_count;

  hazard_unit #(.XLEN_RD(XLEN_RD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id),
    .redirect_exe(redirect_exe),
    .forward_rd1_exe(forward_rd1_exe), .forward_rd2_exe(forward_rd2_exe),
    .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_exe(flush_exe),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int rd; bit rw; bit mr; int rs1; int rs2;
  } instr_t;

  typedef struct {
    int f1; int f2; bit stall; bit fid; bit fex; int sc; int fc;
  } exp_t;

  instr_t inflight [3];  // index = age past ID: 0 EXE, 1 MEM, 2 WB
  instr_t id_m;
  bit     redir_m;
  int     sc_m, fc_m;
  exp_t   cur_e;
  exp_t   exp_q [$];

  int total = 0;
  int bad   = 0;

  function automatic instr_t nop_instr();
    instr_t n;
    n.rd = 0; n.rw = 1'b0; n.mr = 1'b0; n.rs1 = 0; n.rs2 = 0;
    return n;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 3; i++) inflight[i] = nop_instr();
    sc_m = 0;
    fc_m = 0;
  endfunction

  // Youngest older writer of a nonzero register supplies the operand.
  // Its age (1 = MEM, 2 = WB) equals the select code.
  function automatic int source_of(int r);
    if (r == 0) return 0;
    for (int age = 1; age <= 2; age++)
      if (inflight[age].rw && inflight[age].rd == r) return age;
    return 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit   hazard;
    hazard = inflight[0].mr && inflight[0].rw && inflight[0].rd != 0 &&
             (inflight[0].rd == id_m.rs1 || inflight[0].rd == id_m.rs2);
    e.f1    = source_of(inflight[0].rs1);
    e.f2    = source_of(inflight[0].rs2);
    e.stall = hazard && !redir_m && !reset;
    e.fid   = redir_m && !reset;
    e.fex   = (hazard || redir_m) && !reset;
    e.sc    = sc_m;
    e.fc    = fc_m;
    return e;
  endfunction

  // Clock edge: instructions age by one slot.
  function automatic void advance();
    if (reset) begin
      clear_model();
    end else begin
      sc_m = (sc_m + (cur_e.stall ? 1 : 0)) % CMOD;
      fc_m = (fc_m + (cur_e.fid ? 1 : 0)) % CMOD;
      inflight[2] = inflight[1];
      inflight[1] = inflight[0];
      inflight[0] = cur_e.fex ? nop_instr() : id_m;
    end
  endfunction

  function automatic void chk(string name, int got, int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, expv, $time);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic step(input int rs1, input int rs2, input int rd,
                      input bit rw, input bit mr, input bit redir, input bit rst_v);
    @(posedge clk);
    advance();
    #1;
    reset = rst_v;
    if (rst_v) clear_model();
    rs1_id       = XLEN_RD'(rs1);
    rs2_id       = XLEN_RD'(rs2);
    rd_id        = XLEN_RD'(rd);
    RegWrite_id  = rw;
    MemRead_id   = mr;
    redirect_exe = redir;
    id_m.rs1 = rs1; id_m.rs2 = rs2; id_m.rd = rd; id_m.rw = rw; id_m.mr = mr;
    redir_m  = redir;
    cur_e    = predict();
    exp_q.push_back(cur_e);
    $display("cycle: rs1=%0d rs2=%0d rd=%0d rw=%0b mr=%0b redir=%0b rst=%0b -> exp f1=%0d f2=%0d stall=%0b fid=%0b fex=%0b sc=%0d fc=%0d",
             rs1, rs2, rd, rw, mr, redir, rst_v, cur_e.f1, cur_e.f2,
             cur_e.stall, cur_e.fid, cur_e.fex, cur_e.sc, cur_e.fc);
  endtask

  task automatic nop(); step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_fwd1"}, int'(forward_rd1_exe), 0);
    chk({tag, "_fwd2"}, int'(forward_rd2_exe), 0);
    chk({tag, "_stall_if"}, int'(stall_if), 0);
    chk({tag, "_stall_id"}, int'(stall_id), 0);
    chk({tag, "_flush_id"}, int'(flush_id), 0);
    chk({tag, "_flush_exe"}, int'(flush_exe), 0);
    chk({tag, "_stall_cnt"}, int'(stall_count), 0);
    chk({tag, "_flush_cnt"}, int'(flush_count), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwd1", int'(forward_rd1_exe), e.f1);
        chk("fwd2", int'(forward_rd2_exe), e.f2);
        chk("stall_if", int'(stall_if), int'(e.stall));
        chk("stall_id", int'(stall_id), int'(e.stall));
        chk("flush_id", int'(flush_id), int'(e.fid));
        chk("flush_exe", int'(flush_exe), int'(e.fex));
        chk("stall_count", int'(stall_count), e.sc);
        chk("flush_count", int'(flush_count), e.fc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int pairs;
    clear_model();
    cur_e = predict();
    id_m  = nop_instr();
    redir_m = 1'b0;

    // Reset state, with redirect_exe high to check that it is masked.
    #2;
    check_all_zero("reset");
    step(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // add x5 then a reader of x5 (MEM forward), then a reader 3 behind.
    step(1, 2, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5, 3, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    step(5, 0, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    nop(); nop();

    // lw x6 then add rs2=x6: one stall, then WB forward on operand 2.
    step(0, 0, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4, 6, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4, 6, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    nop(); nop(); nop();

    // x7 written by MEM and WB -> MEM wins; x0 writer never forwards.
    step(0, 0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(7, 7, 11, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 0, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    nop(); nop(); nop();

    // Load-use together with a redirect: no stall, both flushes.
    step(0, 0, 9, 1'b1, 1'b1, 1'b0, 1'b0);
    step(9, 0, 13, 1'b1, 1'b0, 1'b1, 1'b0);
    nop(); nop();

    // Stall counter wrap: bring the count to all ones, then one more stall.
    nop(); nop();
    pairs = (CMOD - 1 - sc_m + CMOD) % CMOD;
    for (int i = 0; i < pairs; i++) begin
      step(0, 0, 6, 1'b1, 1'b1, 1'b0, 1'b0);
      step(6, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    nop();
    chk("stall_count_max", int'(stall_count), CMOD - 1);
    step(0, 0, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    step(6, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    nop();
    chk("stall_count_wrap", int'(stall_count), 0);
    nop();

    // Reset asserted while a stall is active, between clock edges.
    step(0, 0, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 6, 14, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    clear_model();
    #1;
    check_all_zero("mid_stall_reset");
    step(0, 6, 14, 1'b1, 1'b0, 1'b1, 1'b1);
    step(0, 6, 14, 1'b1, 1'b0, 1'b0, 1'b1);
    step(0, 6, 14, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();

    // Randomised traffic on a small register range so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0), 1'b0);
    end

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
